// File: rtl/sram_uart_pkg.sv
// sram_uart_pkg: states and frame constants shared by the SRAM-to-UART streamer.
package sram_uart_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        FIN   = 3'd5
    } state_e;
    localparam int FRAME_BITS  = 10;
    localparam int DATA_BITS   = 8;
    localparam int DEF_CLK_DIV = 104;
endpackage

// File: rtl/sram_uart_streamer_if.sv
// sram_uart_streamer_if: control handshake plus shared SRAM read port of the streamer.
interface sram_uart_streamer_if;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic [15:0] addr;
    logic        sram_oe;
    logic [7:0]  sram_din;
    modport master (output start, base_addr, length, sram_din, input busy, done, addr, sram_oe);
    modport slave  (input start, base_addr, length, sram_din, output busy, done, addr, sram_oe);
endinterface

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: 8N1 frame generator; one load strobe sends one byte with exact bit timing.
module uart_tx_shifter
    import sram_uart_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       busy,
    output logic       frame_done,
    output logic       tx
);
    localparam int TW = $clog2(CLK_DIV);
    state_e        phase_q, phase_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          bit_end, last_bit;
    assign bit_end    = tmr_q == TW'(CLK_DIV - 1);
    assign last_bit   = bit_q == 3'(DATA_BITS - 1);
    assign busy       = phase_q != IDLE;
    assign frame_done = phase_q == STOP && bit_end;
    assign tx         = tx_q;
    // The timer wraps exactly when the phase or bit changes, so every entry starts at zero.
    always_comb begin
        phase_d = phase_q;
        tmr_d   = bit_end ? '0 : tmr_q + 1'b1;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (phase_q)
            START: if (bit_end) begin
                phase_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                tx_d    = last_bit ? 1'b1 : shift_q[1];
                phase_d = last_bit ? STOP : DATA;
            end
            STOP: if (bit_end) phase_d = IDLE;
            default: tmr_d = '0;
        endcase
        if (load) begin
            phase_d = START;
            tmr_d   = '0;
            shift_d = din;
            bit_d   = '0;
            tx_d    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            tmr_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: rtl/sram_uart_streamer.sv
// sram_uart_streamer: reads a block of bytes from SRAM and sends each as an 8N1 frame on TX.
module sram_uart_streamer
    import sram_uart_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SRAM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_uart_streamer_if.slave  bus,
    output logic                 TX
);
    localparam int FW = $clog2(SRAM_LAT + 1);
    state_e        state_q, state_d;
    logic [15:0]   ptr_q, ptr_d, rem_q, rem_d, addr_q, addr_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic          fetch_end, load, tx_busy, frame_done;
    assign fetch_end   = fcnt_q == FW'(SRAM_LAT - 1) && !tx_busy;
    assign load        = state_q == FETCH && fetch_end;
    assign bus.addr    = addr_q;
    assign bus.sram_oe = oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    // START spans the whole frame; the shifter sequences start, data and stop bits.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        fcnt_d  = '0;
        case (state_q)
            IDLE: if (bus.start) begin
                ptr_d   = bus.base_addr;
                rem_d   = bus.length;
                state_d = bus.length == 16'd0 ? FIN : FETCH;
            end
            FETCH: begin
                fcnt_d  = fetch_end ? '0 : fcnt_q + 1'b1;
                state_d = fetch_end ? START : FETCH;
            end
            START: if (frame_done) begin
                ptr_d   = ptr_q + 16'd1;
                rem_d   = rem_q - 16'd1;
                state_d = rem_q == 16'd1 ? FIN : FETCH;
            end
            default: state_d = IDLE;
        endcase
        addr_d = state_d == FETCH ? ptr_d : addr_q;
        oe_d   = state_d == FETCH;
        busy_d = state_d inside {FETCH, START, FIN};
        done_d = state_q == FIN;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            fcnt_q  <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    uart_tx_shifter #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk        (clk),
        .rst_n      (reset),
        .load       (load),
        .din        (bus.sram_din),
        .busy       (tx_busy),
        .frame_done (frame_done),
        .tx         (TX)
    );
endmodule

// File: doc/sram_uart_streamer.md
Name: sram_uart_streamer

Overview:
Transmit-side companion to the UART-to-SRAM capture path. On a start command it reads a block of bytes sequentially from the shared SRAM port. It sends each byte out on TX as an 8N1 frame: start bit, 8 data bits LSB first, stop bit. It drives the SRAM address and read-enable itself and reports busy/done to the controlling logic.

Parameters:
CLK_DIV, 104, clk cycles per serial bit (>=2; 104 = 12 MHz / 115200).
SRAM_LAT, 1, clk cycles from addr/sram_oe asserted to sram_din valid (>=1).

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  16  first SRAM address; latched on accepted start
length  input  16  byte count; latched on accepted start; 0 is legal
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the block is finished
addr  output  16  SRAM address
sram_oe  output  1  SRAM read enable, high only during FETCH
sram_din  input  8  SRAM read data
TX  output  1  serial output, idle high

Behaviour:
- Reset (async, reset=0) forces the following values immediately, including mid-frame:
  - state=IDLE, TX=1, busy=0, done=0, sram_oe=0, addr=0.
  - All counters and the shift register are cleared.
- All outputs are registered.
- States: IDLE, FETCH, START, DATA, STOP, FIN.
- IDLE:
  - start=1 latches base_addr into the address pointer and length into the remaining count.
  - If length==0: go to FIN. Otherwise go to FETCH.
  - start is ignored in every state other than IDLE.
- FETCH:
  - addr=pointer, sram_oe=1, held for SRAM_LAT cycles.
  - On the last of those cycles, capture sram_din into the shift register, drop sram_oe, go to START.
- START: TX=0 for CLK_DIV cycles.
- DATA:
  - 8 bits, LSB first, each held CLK_DIV cycles.
  - Shift right after each bit; a 3-bit counter tracks the bit index.
- STOP:
  - TX=1 for CLK_DIV cycles.
  - At the end: pointer += 1 (16-bit, wraps 0xFFFF->0x0000) and remaining -= 1.
  - If remaining becomes 0, go to FIN; otherwise go to FETCH.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Bit timer:
  - Counts 0..CLK_DIV-1 and resets on every state entry.
  - Bit boundaries are exact, with no drift accumulation.
- Inter-byte gap: stop bit, then SRAM_LAT cycles of FETCH with TX held high. No other idle time.
- Total frame duration per byte: 10*CLK_DIV + SRAM_LAT cycles.
- addr holds its last value outside FETCH.
- length=0xFFFF is legal and sends 65535 bytes.

Decomposition:
- Shared package (sram_uart_pkg):
  - state enum.
  - Bits-per-frame constant = 10.
  - Data-bits constant = 8.
  - Default CLK_DIV.
- One natural sub-module: uart_tx_shifter.
  - Contains the bit timer, the shift register and TX generation.
  - Interface: load strobe plus byte in, busy and frame-done out.
  - The streamer FSM handles SRAM sequencing and block counting only.

Test Plan:
- Single byte, CLK_DIV=4, SRAM_LAT=1: SRAM[0x0010]=0x55, start with base=0x0010, length=1.
  - addr=0x0010 with sram_oe for 1 cycle.
  - TX: 4 low, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 high.
  - done pulses once, on the cycle after the stop bit.
- Multi-byte order: SRAM[0x0100..0x0102]=0xA1,0x00,0xFF, length=3.
  - Decoded TX stream is A1,00,FF.
  - Gap between stop bit and next start bit is exactly SRAM_LAT cycles.
- Zero length: start with length=0.
  - sram_oe never rises, TX stays 1.
  - busy rises for 1 cycle, then done pulses and busy returns to 0.
- Address wrap: base=0xFFFF, length=2.
  - Reads addr 0xFFFF then 0x0000.
  - Two frames sent, done pulses once.
- Start while busy: a second start mid-frame, with different base and length.
  - It is ignored; only the original block is sent.
- Reset mid-frame: assert reset during DATA bit 3.
  - TX=1, busy=0, sram_oe=0 in the same cycle.
  - After release, no residual frame is sent and a new start works normally.
